// File: rtl/scan.sv
// scan: time-multiplexed digit scanner for a common-bus 7-segment/BCD display.
// Presents one 4-bit digit at a time on a shared bus together with a one-hot
// enable for the matching digit position. Each digit is held for DIV clocks.
//
// Ports:
//   clk        system scan clock, rising edge
//   clrn       asynchronous reset, active-high (outputs forced to zero while high)
//   datain     packed digits, digit k = datain[4k+3:4k], digit 0 least significant
//   scan_data  value of the currently selected digit
//   scan_en    one-hot digit enable, bit k enables digit k
module scan #(
  parameter int N_DIGITS = 3,
  parameter int DIV      = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [4*N_DIGITS-1:0]   datain,
  output logic [3:0]              scan_data,
  output logic [N_DIGITS-1:0]     scan_en
);

  localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] SEL_MAX = SW'(N_DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [SW-1:0]       sel;
  logic [CW-1:0]       cnt;
  logic [N_DIGITS-1:0] zero_from;
  logic [3:0]          digit;
  logic [N_DIGITS-1:0] onehot;
  logic                blank;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      sel <= '0;
      cnt <= '0;
    end else if (sel > SEL_MAX) begin
      // unreachable in normal operation; recover to the first slot
      sel <= '0;
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      sel <= (sel == SEL_MAX) ? '0 : sel + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // zero_from[k]: digits k..N_DIGITS-1 are all zero (digit k is a leading zero)
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_zero
    assign zero_from[k] = (datain[4*N_DIGITS-1:4*k] == '0);
  end

  always_comb begin
    digit  = '0;
    onehot = '0;
    blank  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (sel == SW'(k)) begin
        digit     = datain[4*k +: 4];
        onehot[k] = 1'b1;
        // digit 0 is never blanked so a zero value still shows "0"
        blank     = (BLANK_LZ != 0) && (k != 0) && zero_from[k];
      end
    end
    if (clrn || blank) begin
      scan_en   = '0;
      scan_data = '0;
    end else begin
      scan_en   = onehot;
      scan_data = digit;
    end
  end

endmodule

// File: tb/tb_scan.sv
// tb_scan: self-checking bench for scan. Three instances cover DIV=1, DIV=4
// and leading-zero blanking. Expected outputs come from a time-based model:
// the slot index is (clocks since release / DIV) mod N.
module tb_scan;

  logic        clk = 1'b0;
  logic        clrn1, clrn4, clrnb;
  logic [11:0] d1, d4, db;
  logic [3:0]  data1, data4, datab;
  logic [2:0]  en1, en4, enb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scan #(.N_DIGITS(3), .DIV(1), .BLANK_LZ(0)) u_div1 (
    .clk(clk), .clrn(clrn1), .datain(d1), .scan_data(data1), .scan_en(en1));
  scan #(.N_DIGITS(3), .DIV(4), .BLANK_LZ(0)) u_div4 (
    .clk(clk), .clrn(clrn4), .datain(d4), .scan_data(data4), .scan_en(en4));
  scan #(.N_DIGITS(3), .DIV(1), .BLANK_LZ(1)) u_blank (
    .clk(clk), .clrn(clrnb), .datain(db), .scan_data(datab), .scan_en(enb));

  // returns {scan_en, scan_data} expected t clocks after reset release
  function automatic logic [6:0] model(input logic [11:0] d, input int t,
                                       input int div, input bit blank_lz);
    int          s;
    logic [11:0] upper;
    logic [2:0]  en;
    logic [3:0]  dig;
    s     = (t / div) % 3;
    upper = d >> (4 * s);
    dig   = upper[3:0];
    en    = 3'b001 << s;
    if (blank_lz && s != 0 && upper == 12'h000) begin
      en  = 3'b000;
      dig = 4'h0;
    end
    return {en, dig};
  endfunction

  task automatic test_reset();
    clrn1 = 1'b1; clrn4 = 1'b1; clrnb = 1'b1;
    d1 = 12'h000; d4 = 12'h000; db = 12'h000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      tests++;
      if ({en1, data1, en4, data4, enb, datab} !== 21'd0) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: got en1=%b d1=%h en4=%b d4=%h enb=%b db=%h, want all zero",
                 i, en1, data1, en4, data4, enb, datab);
      end
    end
    // asynchronous assertion mid-cycle with nonzero data
    d1 = 12'h123;
    @(negedge clk); clrn1 = 1'b0;
    @(negedge clk); @(posedge clk); #2;
    clrn1 = 1'b1; #1;
    tests++;
    if ({en1, data1} !== 7'd0) begin
      fails++;
      $display("FAIL reset_async: got en=%b data=%h, want en=000 data=0", en1, data1);
    end
  endtask

  task automatic test_basic_scan();
    logic [6:0] exp;
    clrn1 = 1'b1; d1 = 12'h123;
    @(negedge clk); clrn1 = 1'b0; #1;
    for (int t = 0; t < 9; t++) begin
      if (t > 0) begin @(negedge clk); #1; end
      exp = model(d1, t, 1, 1'b0);
      tests++;
      if ({en1, data1} !== exp) begin
        fails++;
        $display("FAIL basic_scan t=%0d: got en=%b data=%h, want en=%b data=%h",
                 t, en1, data1, exp[6:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_data_change();
    clrn1 = 1'b1; d1 = 12'h123;
    @(negedge clk); clrn1 = 1'b0;
    @(negedge clk); #1;          // sel = 1
    d1 = 12'h456; #1;
    tests++;
    if ({en1, data1} !== {3'b010, 4'h5}) begin
      fails++;
      $display("FAIL data_change_same_cycle: got en=%b data=%h, want en=010 data=5", en1, data1);
    end
    @(negedge clk); #1;
    tests++;
    if ({en1, data1} !== {3'b100, 4'h4}) begin
      fails++;
      $display("FAIL data_change_next: got en=%b data=%h, want en=100 data=4", en1, data1);
    end
    @(negedge clk); #1;
    tests++;
    if ({en1, data1} !== {3'b001, 4'h6}) begin
      fails++;
      $display("FAIL data_change_wrap: got en=%b data=%h, want en=001 data=6", en1, data1);
    end
  endtask

  task automatic test_prescaler();
    logic [6:0] exp;
    clrn4 = 1'b1; d4 = 12'h789;
    @(negedge clk); clrn4 = 1'b0; #1;
    for (int t = 0; t < 26; t++) begin
      if (t > 0) begin @(negedge clk); #1; end
      exp = model(d4, t, 4, 1'b0);
      tests++;
      if ({en4, data4} !== exp) begin
        fails++;
        $display("FAIL prescaler t=%0d: got en=%b data=%h, want en=%b data=%h",
                 t, en4, data4, exp[6:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    clrn4 = 1'b1; d4 = 12'h789;
    @(negedge clk); clrn4 = 1'b0;
    for (int t = 0; t < 9; t++) @(negedge clk);   // t=9 -> digit 2 selected
    #1;
    tests++;
    if ({en4, data4} !== {3'b100, 4'h7}) begin
      fails++;
      $display("FAIL reset_mid_pre: got en=%b data=%h, want en=100 data=7", en4, data4);
    end
    #1; clrn4 = 1'b1; #1;
    tests++;
    if ({en4, data4} !== 7'd0) begin
      fails++;
      $display("FAIL reset_mid_async: got en=%b data=%h, want zero", en4, data4);
    end
    @(negedge clk); clrn4 = 1'b0; #1;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) begin @(negedge clk); #1; end
      exp = model(d4, t, 4, 1'b0);
      tests++;
      if ({en4, data4} !== exp) begin
        fails++;
        $display("FAIL reset_mid_restart t=%0d: got en=%b data=%h, want en=%b data=%h",
                 t, en4, data4, exp[6:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [11:0] pats [3];
    logic [6:0]  exp;
    pats[0] = 12'h005; pats[1] = 12'h000; pats[2] = 12'h050;
    for (int p = 0; p < 3; p++) begin
      clrnb = 1'b1; db = pats[p];
      @(negedge clk); clrnb = 1'b0; #1;
      for (int t = 0; t < 6; t++) begin
        if (t > 0) begin @(negedge clk); #1; end
        exp = model(db, t, 1, 1'b1);
        tests++;
        if ({enb, datab} !== exp) begin
          fails++;
          $display("FAIL blanking d=%h t=%0d: got en=%b data=%h, want en=%b data=%h",
                   db, t, enb, datab, exp[6:4], exp[3:0]);
        end
      end
    end
  endtask

  // random data changing every cycle on all three instances, one shared timeline
  task automatic test_random();
    logic [6:0] e1, e4, eb;
    clrn1 = 1'b1; clrn4 = 1'b1; clrnb = 1'b1;
    @(negedge clk); clrn1 = 1'b0; clrn4 = 1'b0; clrnb = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) @(negedge clk);
      d1 = 12'($urandom);
      d4 = 12'($urandom);
      for (int k = 0; k < 3; k++)                // sparse nibbles to exercise blanking
        db[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      #1;
      e1 = model(d1, t, 1, 1'b0);
      e4 = model(d4, t, 4, 1'b0);
      eb = model(db, t, 1, 1'b1);
      tests++;
      if ({en1, data1} !== e1 || {en4, data4} !== e4 || {enb, datab} !== eb) begin
        fails++;
        $display("FAIL random t=%0d: got %b/%h %b/%h %b/%h, want %b/%h %b/%h %b/%h",
                 t, en1, data1, en4, data4, enb, datab,
                 e1[6:4], e1[3:0], e4[6:4], e4[3:0], eb[6:4], eb[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_data_change();
    test_prescaler();
    test_reset_mid();
    test_blanking();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan.md
Name: scan

Overview:
- Time-multiplexed digit scanner for a common-bus 7-segment/BCD display.
- Takes a packed word of N 4-bit digits and presents one digit at a time on a shared 4-bit bus.
- Drives a one-hot enable for the matching digit position.
- Sits between the counting/accounting datapath (source of datain) and the display decoder/driver pins.

Parameters:
- N_DIGITS, 3, number of multiplexed digits; must be ≥ 2.
- DIV, 1, clocks per digit slot; must be ≥ 1. Default 1 means the scan advances every clock, i.e. 1 ms per digit at the 1 kHz system clock.
- BLANK_LZ, 0, when 1, leading-zero digits are blanked (enable held low). The least significant digit is never blanked.

Ports:
- clk  in  1  system scan clock; rising-edge active.
- clrn  in  1  reset, asynchronous, active-high.
- datain  in  4*N_DIGITS  packed digits; digit k = datain[4k+3:4k], digit 0 = least significant.
- scan_data  out  4  value of the currently selected digit.
- scan_en  out  N_DIGITS  one-hot digit enable, active-high; bit k enables digit k.

Behaviour:
- One clock domain, clk. Reset clrn is asynchronous and active-high.
- State:
  - Digit selector sel, range 0..N_DIGITS-1, width ceil(log2(N_DIGITS)).
  - Prescaler cnt, range 0..DIV-1.
- While clrn=1:
  - sel=0 and cnt=0, asynchronously.
  - scan_en=0 (all digits off) and scan_data=0.
- When clrn=0, on each rising edge of clk:
  - If cnt==DIV-1: cnt←0, and sel←sel+1, wrapping from N_DIGITS-1 to 0.
  - Otherwise: cnt←cnt+1.
- Outputs when not in reset are combinational from sel and datain:
  - scan_data = digit[sel].
  - scan_en = 1<<sel.
  - A datain change is visible on scan_data in the same cycle; there is no capture register.
- Scan order: digit 0, then 1, …, then N_DIGITS-1, then back to 0. Each digit is held for exactly DIV clocks.
- After reset release, digit 0 is presented for DIV full clocks before the first advance.
- Exactly one scan_en bit is high at any time out of reset, unless blanking applies.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k > 0 is blank iff digits k..N_DIGITS-1 are all zero.
  - While a blank digit is selected, scan_en=0 and scan_data=0.
  - The selector still steps through blank slots, so the refresh period is constant.
- Reset mid-scan: outputs go to zero immediately and asynchronously. The scan restarts at digit 0 after release.
- Non-BCD nibbles (A–F) are passed through unchanged; decoding is downstream.
- No illegal sel states are reachable. If sel ≥ N_DIGITS is ever reached, the next edge forces sel←0.

Test Plan:
1. Reset: clrn=1 for 5 clocks with datain=12'h000 -> scan_en=3'b000 and scan_data=0 throughout. Assert clrn mid-cycle -> outputs zero without waiting for a clock edge.
2. Basic scan, DIV=1, datain=12'h123, clrn released -> per-clock sequence:
   - (scan_en,scan_data) = (001,3), (010,2), (100,1), (001,3), …
   - Period is 3 clocks.
3. Data change mid-scan: datain changes to 12'h456 while sel=1 -> scan_data=5 in the same cycle. Following slots give (100,4) then (001,6). No glitch on scan_en.
4. Prescaler, DIV=4, datain=12'h789 -> each digit is held exactly 4 clocks. Sequence: 9×4, 8×4, 7×4, then repeat.
5. Reset mid-operation: assert clrn while sel=2 -> outputs are 0 immediately. On release, digit 0 is shown first for DIV clocks.
6. Blanking, BLANK_LZ=1, DIV=1:
   - datain=12'h005 -> scan_en sequence 001, 000, 000, …; scan_data 5, 0, 0.
   - datain=12'h000 -> digit 0 still enabled, showing 0.
   - datain=12'h050 -> scan_en sequence 001, 010, 000; scan_data 0, 5, 0.
